// File: rtl/samp_pkg.sv
// Shared constants, state type and parity helper for the sample column serializer.
// Optional build macro: SAMP_SER_PARITY_EN (parity bit on column bit 12).
package samp_pkg;

  localparam int SAMPLE_BITS = 12;
  localparam int NUM_SAMPLES = 3;
  localparam int COL_WIDTH   = 16;
  localparam int WINDOW_BITS = SAMPLE_BITS * NUM_SAMPLES;
  localparam int CNT_BITS    = $clog2(NUM_SAMPLES);

  localparam logic [COL_WIDTH-1:0]   COL_IDLE_VALUE = '1;
  // Receiver (sample shift register) comes out of reset holding all ones.
  localparam logic [WINDOW_BITS-1:0] RX_RESET_VALUE = '1;
  localparam logic [CNT_BITS-1:0]    LAST_COL       = CNT_BITS'(NUM_SAMPLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic logic even_parity(input logic [SAMPLE_BITS-1:0] s);
    return ^s;
  endfunction

endpackage

// File: rtl/samp_col_serializer.sv
// Captures a 3-sample window and emits it oldest-first, one column per valid/ready transfer.
// Optional build macro: SAMP_SER_PARITY_EN (col_out[12] carries even parity of the sample).
//
// state | meaning
// IDLE  | bus parked at 16'hFFFF, waiting for a window
// SEND  | presenting column r_col_cnt, waiting for col_ready
module samp_col_serializer
  import samp_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load,
  input  logic [WINDOW_BITS-1:0] sample_in,
  output logic                   load_ready,
  output logic [COL_WIDTH-1:0]   col_out,
  output logic                   col_valid,
  input  logic                   col_ready,
  output logic                   done
);

  ser_state_t             r_state;
  logic [CNT_BITS-1:0]    r_col_cnt;
  logic [WINDOW_BITS-1:0] r_shadow;
  logic                   r_done;

  logic                   w_send;
  logic                   w_last;
  logic                   w_xfer;
  logic                   w_load;
  logic [SAMPLE_BITS-1:0] w_sample;
  logic [COL_WIDTH-1:0]   w_col;

  assign w_send     = (r_state == SEND);
  assign w_last     = (r_col_cnt == LAST_COL);
  assign w_xfer     = w_send & col_ready;
  // Accepting a new window during the final transfer keeps the stream gap-free.
  assign load_ready = ~w_send | (w_last & col_ready);
  assign w_load     = load & load_ready;
  assign w_sample   = r_shadow[32'(r_col_cnt) * SAMPLE_BITS +: SAMPLE_BITS];

  always_comb begin
    w_col = COL_IDLE_VALUE;
    if (w_send) begin
      w_col                   = '0;
      w_col[SAMPLE_BITS-1:0]  = w_sample;
`ifdef SAMP_SER_PARITY_EN
      w_col[SAMPLE_BITS]      = even_parity(w_sample);
`else
      w_col[COL_WIDTH-1:SAMPLE_BITS] = '0;
`endif
    end
  end

  assign col_out   = w_col;
  assign col_valid = w_send;
  assign done      = r_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_col_cnt <= '0;
      r_shadow  <= '1;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_xfer & w_last;
      if (w_load) begin
        r_shadow  <= sample_in;
        r_col_cnt <= '0;
        r_state   <= SEND;
      end else if (w_xfer) begin
        if (w_last) begin
          r_state   <= IDLE;
          r_col_cnt <= '0;
        end else begin
          r_col_cnt <= r_col_cnt + CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_samp_col_serializer.sv
// Directed bench for samp_col_serializer with a behavioural loopback receiver.
// Honours SAMP_SER_PARITY_EN for expected column values.
module tb_samp_col_serializer;
  import samp_pkg::*;

  logic                   clk = 1'b0;
  logic                   n_rst;
  logic                   load;
  logic [WINDOW_BITS-1:0] sample_in;
  logic                   load_ready;
  logic [COL_WIDTH-1:0]   col_out;
  logic                   col_valid;
  logic                   col_ready;
  logic                   done;
  logic [WINDOW_BITS-1:0] rx;

  int total = 0;
  int bad   = 0;

  localparam logic [WINDOW_BITS-1:0] WIN_A = 36'h12C_0C8_064;
  localparam logic [WINDOW_BITS-1:0] WIN_B = 36'h000_FFF_001;
  localparam logic [WINDOW_BITS-1:0] WIN_X = 36'hAAA_AAA_AAA;
`ifdef SAMP_SER_PARITY_EN
  localparam logic [15:0] C064 = 16'h1064;
  localparam logic [15:0] C0C8 = 16'h10C8;
  localparam logic [15:0] C12C = 16'h012C;
  localparam logic [15:0] C001 = 16'h1001;
  localparam logic [15:0] CFFF = 16'h0FFF;
  localparam logic [15:0] C000 = 16'h0000;
`else
  localparam logic [15:0] C064 = 16'h0064;
  localparam logic [15:0] C0C8 = 16'h00C8;
  localparam logic [15:0] C12C = 16'h012C;
  localparam logic [15:0] C001 = 16'h0001;
  localparam logic [15:0] CFFF = 16'h0FFF;
  localparam logic [15:0] C000 = 16'h0000;
`endif

  samp_col_serializer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (load),
    .sample_in  (sample_in),
    .load_ready (load_ready),
    .col_out    (col_out),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Shift-register receiver: oldest column lands in the LSBs after three shifts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rx <= RX_RESET_VALUE;
    else if (col_valid & col_ready) rx <= {col_out[SAMPLE_BITS-1:0], rx[WINDOW_BITS-1:SAMPLE_BITS]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_col(input string name, input logic [15:0] exp_col, input logic exp_valid, input logic exp_done);
    total++;
    if (col_out !== exp_col || col_valid !== exp_valid || done !== exp_done) begin
      bad++;
      $display("FAIL %s: col_out=%h valid=%b done=%b, required col_out=%h valid=%b done=%b",
               name, col_out, col_valid, done, exp_col, exp_valid, exp_done);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; load = 1'b0; sample_in = '0; col_ready = 1'b1;
    tick(); tick();
    n_rst = 1'b1;
    tick();
    total++;
    if (load_ready !== 1'b1 || col_valid !== 1'b0 || col_out !== 16'hFFFF) begin
      bad++;
      $display("FAIL reset_release: load_ready=%b valid=%b col_out=%h, required 1 0 ffff", load_ready, col_valid, col_out);
    end
    // col_ready in IDLE must not start anything
    tick();
    chk_col("idle_ready_ignored", 16'hFFFF, 1'b0, 1'b0);
    load = 1'b1; sample_in = WIN_A;
    tick();
    load = 1'b0;
    chk_col("reset_pre_first_col", C064, 1'b1, 1'b0);
    #3 n_rst = 1'b0;
    #1;
    chk_col("reset_async", 16'hFFFF, 1'b0, 1'b0);
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_async_load_ready: got %b, required 1", load_ready);
    end
    tick();
    chk_col("reset_hold", 16'hFFFF, 1'b0, 1'b0);
    n_rst = 1'b1;
    tick();
    chk_col("reset_after_release", 16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    col_ready = 1'b1; load = 1'b1; sample_in = WIN_A;
    tick();
    load = 1'b0; sample_in = '0;
    chk_col("single_col0", C064, 1'b1, 1'b0);
    tick();
    chk_col("single_col1", C0C8, 1'b1, 1'b0);
    tick();
    chk_col("single_col2", C12C, 1'b1, 1'b0);
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_last_load_ready: got %b, required 1", load_ready);
    end
    tick();
    chk_col("single_done", 16'hFFFF, 1'b0, 1'b1);
    total++;
    if (rx !== WIN_A) begin
      bad++;
      $display("FAIL loopback_at_done: rx=%h, required %h", rx, WIN_A);
    end
    tick();
    chk_col("single_idle", 16'hFFFF, 1'b0, 1'b0);
    total++;
    if (rx !== 36'h12C0C8064) begin
      bad++;
      $display("FAIL loopback_after_done: rx=%h, required 12c0c8064", rx);
    end
  endtask

  task automatic test_stall();
    col_ready = 1'b1; load = 1'b1; sample_in = WIN_A;
    tick();
    load = 1'b0;
    chk_col("stall_col0", C064, 1'b1, 1'b0);
    col_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_col($sformatf("stall_hold%0d", i), C064, 1'b1, 1'b0);
      total++;
      if (load_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_load_ready%0d: got %b, required 0", i, load_ready);
      end
    end
    col_ready = 1'b1;
    tick();
    chk_col("stall_col1", C0C8, 1'b1, 1'b0);
    tick();
    chk_col("stall_col2", C12C, 1'b1, 1'b0);
    tick();
    chk_col("stall_done", 16'hFFFF, 1'b0, 1'b1);
    tick();
    chk_col("stall_done_once", 16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    col_ready = 1'b1; load = 1'b1; sample_in = WIN_A;
    tick();
    load = 1'b0;
    chk_col("b2b_a0", C064, 1'b1, 1'b0);
    tick();
    chk_col("b2b_a1", C0C8, 1'b1, 1'b0);
    tick();
    chk_col("b2b_a2", C12C, 1'b1, 1'b0);
    load = 1'b1; sample_in = WIN_B;
    tick();
    load = 1'b0; sample_in = '0;
    chk_col("b2b_b0", C001, 1'b1, 1'b1);
    tick();
    chk_col("b2b_b1", CFFF, 1'b1, 1'b0);
    tick();
    chk_col("b2b_b2", C000, 1'b1, 1'b0);
    tick();
    chk_col("b2b_done", 16'hFFFF, 1'b0, 1'b1);
    total++;
    if (rx !== WIN_B) begin
      bad++;
      $display("FAIL b2b_loopback: rx=%h, required %h", rx, WIN_B);
    end
    tick();
    chk_col("b2b_idle", 16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_load_and_reset();
    col_ready = 1'b1; load = 1'b1; sample_in = WIN_A;
    tick();
    load = 1'b0;
    chk_col("ign_col0", C064, 1'b1, 1'b0);
    tick();
    chk_col("ign_col1", C0C8, 1'b1, 1'b0);
    load = 1'b1; sample_in = WIN_X;
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL ign_load_ready: got %b, required 0", load_ready);
    end
    tick();
    load = 1'b0; sample_in = '0;
    chk_col("ign_col2", C12C, 1'b1, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    chk_col("midreset_now", 16'hFFFF, 1'b0, 1'b0);
    tick();
    chk_col("midreset_no_done", 16'hFFFF, 1'b0, 1'b0);
    n_rst = 1'b1;
    tick();
    chk_col("midreset_released", 16'hFFFF, 1'b0, 1'b0);
    tick();
    chk_col("midreset_still_idle", 16'hFFFF, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_ignored_load_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000ns");
    $fatal(1, "timeout");
  end

endmodule
